// File: rtl/shift_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier and its companion divider:
// state encoding, counter-width helper and default operand width.
package shift_mult_pkg;

   localparam int SHIFT_MULT_N_DEFAULT = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_ADD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // The counter must hold the value N itself, not just N-1.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/shift_mult_shift_add_step.sv
// One multiplier iteration: shift the 2N-bit accumulator left by one and
// conditionally add the zero-extended multiplicand.
module shift_add_step
   import shift_mult_pkg::*;
#(
   parameter int N = SHIFT_MULT_N_DEFAULT
) (
   input  logic [2*N-1:0] acc,
   input  logic [N-1:0]   a,
   input  logic           bit_b,
   output logic [2*N-1:0] acc_next
);

   assign acc_next = {acc[2*N-2:0], 1'b0} + (bit_b ? {{N{1'b0}}, a} : {(2*N){1'b0}});

endmodule

// File: rtl/shift_mult.sv
// Sequential MSB-first shift-and-add multiplier: producto = A*B (+ R when
// SHIFT_MULT_REMAINDER_EN is defined, which adds the residuo port and ADD state).
module shift_mult
   import shift_mult_pkg::*;
#(
   parameter int N = SHIFT_MULT_N_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   multiplicando,
   input  logic [N-1:0]   multiplicador,
`ifdef SHIFT_MULT_REMAINDER_EN
   input  logic [N-1:0]   residuo,
`endif
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] producto
);

   localparam int CW = cnt_width(N);

   state_t            state_q, state_d;
   logic [2*N-1:0]    acc_q;
   logic [2*N-1:0]    acc_step;
   logic [N-1:0]      a_q;
   logic [N-1:0]      b_q;
   logic [CW-1:0]     cnt_q;
`ifdef SHIFT_MULT_REMAINDER_EN
   logic [N-1:0]      r_q;
`endif

   // b_q shifts left each RUN cycle, so its MSB is always B[cnt-1].
   shift_add_step #(.N(N)) u_step (
      .acc      (acc_q),
      .a        (a_q),
      .bit_b    (b_q[N-1]),
      .acc_next (acc_step)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            if (cnt_q == CW'(1)) begin
`ifdef SHIFT_MULT_REMAINDER_EN
               state_d = S_ADD;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef SHIFT_MULT_REMAINDER_EN
         S_ADD:  state_d = S_DONE;
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
`ifdef SHIFT_MULT_REMAINDER_EN
         r_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q   <= multiplicando;
                  b_q   <= multiplicador;
`ifdef SHIFT_MULT_REMAINDER_EN
                  r_q   <= residuo;
`endif
                  acc_q <= '0;
                  cnt_q <= CW'(N);
               end
            end
            S_RUN: begin
               acc_q <= acc_step;
               b_q   <= {b_q[N-2:0], 1'b0};
               cnt_q <= cnt_q - CW'(1);
            end
`ifdef SHIFT_MULT_REMAINDER_EN
            S_ADD: acc_q <= acc_q + {{N{1'b0}}, r_q};
`endif
            default: ;
         endcase
      end
   end

   assign busy     = (state_q == S_RUN) || (state_q == S_ADD);
   assign done     = (state_q == S_DONE);
   assign producto = acc_q;

endmodule

// File: tb/tb_shift_mult.sv
// Self-checking bench for shift_mult: cycle model of outputs plus directed
// vectors with literal results, latency, busy length and throughput.
module tb_shift_mult;

   localparam int N = 8;
`ifdef SHIFT_MULT_REMAINDER_EN
   localparam bit REM = 1'b1;
`else
   localparam bit REM = 1'b0;
`endif
   // number of edges after the accepting edge until done is visible
   localparam int KD = REM ? N + 1 : N;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [N-1:0]   multiplicando = '0;
   logic [N-1:0]   multiplicador = '0;
   logic [N-1:0]   residuo = '0;
   logic           busy;
   logic           done;
   logic [2*N-1:0] producto;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   int             mk = -1;
   logic [N-1:0]   ma = '0, mb = '0, mr = '0;
   logic [2*N-1:0] mlast = '0;

   always #5 clk = ~clk;

   shift_mult #(.N(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .multiplicando (multiplicando),
      .multiplicador (multiplicador),
`ifdef SHIFT_MULT_REMAINDER_EN
      .residuo       (residuo),
`endif
      .busy          (busy),
      .done          (done),
      .producto      (producto)
   );

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // model: mk = edges since acceptance, -1 or KD+1 means idle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mk = -1;
         mlast = '0;
      end else if (mk < 0 || mk == KD + 1) begin
         if (start) begin
            ma = multiplicando;
            mb = multiplicador;
            mr = REM ? residuo : '0;
            mk = 0;
         end
      end else begin
         mk++;
         if (mk == KD) mlast = 16'(ma) * 16'(mb) + 16'(mr);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [2*N-1:0] ep;
         if (mk < 0 || mk == KD + 1)      ep = mlast;
         else if (mk <= N)                ep = 16'(ma) * (16'(mb) >> (N - mk));
         else                             ep = 16'(ma) * 16'(mb) + 16'(mr);
         check("busy", busy, (mk >= 0 && mk < KD) ? 1 : 0);
         check("done", done, (mk == KD) ? 1 : 0);
         check("producto", producto, ep);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] r,
                        input longint exp_p, input bit poke, input string nm);
      int cyc, bc;
      multiplicando = a;
      multiplicador = b;
      residuo       = r;
      start         = 1'b1;
      tick();
      start         = 1'b0;
      multiplicando = ~a;
      multiplicador = ~b;
      residuo       = ~r;
      cyc = 0;
      bc  = 0;
      while (!done && cyc < 40) begin
         if (busy) bc++;
         if (poke && cyc == 3) begin
            start = 1'b1;
            multiplicando = 1;
            multiplicador = 1;
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      check({nm, "_latency"}, cyc + 1, KD + 1);
      check({nm, "_busy_len"}, bc, KD);
      check({nm, "_result"}, producto, exp_p);
      tick();
      check({nm, "_held"}, producto, exp_p);
   endtask

   initial begin
      int c, nd;
      repeat (3) @(posedge clk);
      #2;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_producto", producto, 0);
      rst = 1'b0;
      chk_en = 1'b1;
      tick();

      // abort mid-RUN
      multiplicando = 9; multiplicador = 9; residuo = 0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_producto", producto, 0);
      tick();
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) nd++;
         tick();
      end
      check("abort_no_done", nd, 0);
      do_op(2, 2, 0, 4, 1'b0, "after_abort");

      do_op(7, 5, 3, REM ? 38 : 35, 1'b0, "a7b5r3");
      do_op(255, 255, 255, REM ? 65280 : 65025, 1'b0, "max");
      do_op(0, 200, 9, REM ? 9 : 0, 1'b0, "a0");
      do_op(13, 0, 0, 0, 1'b0, "b0");
      do_op(6, 4, 1, REM ? 25 : 24, 1'b1, "ignore_start");
      do_op(12, 11, 0, 132, 1'b0, "a12b11");

      // start held high: back-to-back operations
      multiplicando = 3; multiplicador = 4; residuo = 1; start = 1'b1;
      c = 0;
      while (!done && c < 40) begin tick(); c++; end
      check("b2b_first_result", producto, REM ? 13 : 12);
      tick();
      c = 1;
      while (!done && c < 40) begin tick(); c++; end
      check("b2b_spacing", c, KD + 2);
      check("b2b_second_result", producto, REM ? 13 : 12);
      start = 1'b0;
      repeat (2 * KD + 4) tick();
      check("final_idle_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_mult.md
# shift_mult

Sequential shift-and-add multiplier: the inverse of the divider's shift datapath. It rebuilds a dividend from quotient, divisor and remainder, `producto = multiplicando * multiplicador + residuo`, scanning the multiplier MSB-first one bit per clock. It sits beside the divider as its check and reconstruction path, and it can also serve as a standalone unsigned multiplier.

## Interface
- `N`, default 8: operand width in bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE.
- `multiplicando`  in  N: operand A, usually the divisor. Latched on accepted `start`.
- `multiplicador`  in  N: operand B, usually the quotient. Latched on accepted `start`.
- `residuo`  in  N: addend R, usually the remainder. Latched on accepted `start`. Present only with `SHIFT_MULT_REMAINDER_EN`.
- `busy`  out  1: high from the cycle after an accepted `start` until DONE is entered.
- `done`  out  1: one-cycle pulse while in DONE.
- `producto`  out  2N: result. Held stable from `done` until the next accepted `start`.

## Operation
- Reset values:
  - state IDLE, accumulator 0, bit counter 0;
  - `busy`=0, `done`=0, `producto`=0.
- States: IDLE, RUN, ADD, DONE.
- IDLE:
  - On `start`=1: latch A, B, R.
  - Clear the accumulator and load the counter with N.
  - Go to RUN.
- RUN, each cycle:
  - `acc <= (acc << 1) + (B[cnt-1] ? {N'b0,A} : 0)`, then `cnt <= cnt-1`.
  - When `cnt` reaches 1 in this cycle, go to ADD.
  - Bits are consumed MSB-first, index N-1 down to 0.
- ADD: `acc <= acc + {N'b0,R}`, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Width rule:
  - The accumulator is 2N bits, unsigned. Overflow is impossible because (2^N-1)^2 + (2^N-1) < 2^(2N).
  - The counter is $clog2(N+1) bits. No wrap is permitted.
- `producto` is driven directly from the accumulator. It changes only in RUN and ADD and after an accepted `start`.
- Boundary conditions:
  - `start` while not IDLE is ignored. There is no queueing.
  - `start` held high across DONE→IDLE starts a new operation on the first IDLE cycle.
  - Input changes after acceptance have no effect.
  - Reset mid-operation aborts immediately to reset values. No `done` is emitted.
  - A=0 or B=0 gives `producto`=R.

## Timing
- The accepting edge is edge 0.
- RUN occupies edges 1..N, ADD is edge N+1, and `done` is high in the cycle following edge N+1.
- Total latency from the `start` sample to `done` high is N+2 cycles. With `N`=8 that is 10.
- `busy` is high for N+1 cycles.
- Throughput is one result per N+3 cycles with `start` held high.

## Configuration
- `SHIFT_MULT_REMAINDER_EN` defined:
  - The `residuo` port and the ADD state exist.
  - Latency is N+2.
- Not defined:
  - No `residuo` port and no ADD state; RUN goes directly to DONE.
  - `producto` = A*B.
  - Latency is N+1, `busy` is high for N cycles, and throughput is one result per N+2 cycles.

## Structure
- Shared package holds:
  - the state encoding localparams `S_IDLE`, `S_RUN`, `S_ADD`, `S_DONE`;
  - the counter-width function;
  - the default `N`.
- The divider uses the same package for its state names.
- One natural sub-module, `shift_add_step`: combinational, 2N-bit shift-left-by-one plus conditional add of A. It is instantiated once in RUN.
- Control FSM and counter stay in `shift_mult`.

## Test plan
- Reset mid-RUN: `rst` pulse at cycle 3 -> `busy`=0, `producto`=0, no `done`. A following `start` with A=2, B=2, R=0 -> 4.
- N=8, A=7, B=5, R=3 -> `done` at cycle 10 after `start`, `producto`=38. `busy` high for exactly 9 cycles.
- A=255, B=255, R=255 -> `producto`=65280 (0xFF00), no overflow.
- A=0, B=200, R=9 -> 9. Separately, A=13, B=0, R=0 -> 0.
- `start` pulsed while busy with A=1, B=1 -> ignored. The original A=6, B=4, R=1 result, 25, is unchanged.
- Macro undefined: A=12, B=11 -> 132 with `done` at cycle 9. Back-to-back `start` held high -> results every 10 cycles.
